// File: rtl/instr_encoder_pkg.sv
// Shared MIPS encoding constants, request payload and field-packing helpers.
// The decoder compares against these same opcode/funct values.
package instr_encoder_pkg;

  localparam int unsigned KIND_W = 4;
  localparam int unsigned REG_W  = 5;
  localparam int unsigned IMM_W  = 16;
  localparam int unsigned TGT_W  = 26;
  localparam int unsigned OP_W   = 6;
  localparam int unsigned FN_W   = 6;
  localparam int unsigned WORD_W = 32;

  localparam logic [KIND_W-1:0] KIND_ADDU  = 4'd0;
  localparam logic [KIND_W-1:0] KIND_SUBU  = 4'd1;
  localparam logic [KIND_W-1:0] KIND_ORI   = 4'd2;
  localparam logic [KIND_W-1:0] KIND_LW    = 4'd3;
  localparam logic [KIND_W-1:0] KIND_SW    = 4'd4;
  localparam logic [KIND_W-1:0] KIND_BEQ   = 4'd5;
  localparam logic [KIND_W-1:0] KIND_LUI   = 4'd6;
  localparam logic [KIND_W-1:0] KIND_ADDI  = 4'd7;
  localparam logic [KIND_W-1:0] KIND_ADDIU = 4'd8;
  localparam logic [KIND_W-1:0] KIND_SLT   = 4'd9;
  localparam logic [KIND_W-1:0] KIND_J     = 4'd10;
  localparam logic [KIND_W-1:0] KIND_JAL   = 4'd11;
  localparam logic [KIND_W-1:0] KIND_JR    = 4'd12;

  localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
  localparam logic [OP_W-1:0] OP_ADDIU = 6'b001001;
  localparam logic [OP_W-1:0] OP_ORI   = 6'b001101;
  localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OP_W-1:0] OP_LUI   = 6'b001111;
  localparam logic [OP_W-1:0] OP_J     = 6'b000010;
  localparam logic [OP_W-1:0] OP_JAL   = 6'b000011;

  localparam logic [FN_W-1:0] FN_ADDU = 6'b100001;
  localparam logic [FN_W-1:0] FN_SUBU = 6'b100011;
  localparam logic [FN_W-1:0] FN_SLT  = 6'b101010;
  localparam logic [FN_W-1:0] FN_JR   = 6'b001000;

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_STOP} state_e;

  typedef struct packed {
    logic [KIND_W-1:0] kind;
    logic [REG_W-1:0]  rs;
    logic [REG_W-1:0]  rt;
    logic [REG_W-1:0]  rd;
    logic [IMM_W-1:0]  imm;
    logic [TGT_W-1:0]  target;
  } req_t;

  // R-type word; shamt is always zero.
  function automatic logic [WORD_W-1:0] r_word(input logic [REG_W-1:0] rs,
                                                input logic [REG_W-1:0] rt,
                                                input logic [REG_W-1:0] rd,
                                                input logic [FN_W-1:0]  fn);
    return {OP_RTYPE, rs, rt, rd, 5'd0, fn};
  endfunction

  function automatic logic [WORD_W-1:0] i_word(input logic [OP_W-1:0]  op,
                                                input logic [REG_W-1:0] rs,
                                                input logic [REG_W-1:0] rt,
                                                input logic [IMM_W-1:0] imm);
    return {op, rs, rt, imm};
  endfunction

endpackage

// File: rtl/instr_encoder_if.sv
// Request stream in, instruction-memory write port out.
interface instr_encoder_if
  import instr_encoder_pkg::*;
#(
  parameter int unsigned ADDR_W = 10
) ();

  logic              in_valid;
  logic              in_ready;
  logic [KIND_W-1:0] in_kind;
  logic [REG_W-1:0]  in_rs;
  logic [REG_W-1:0]  in_rt;
  logic [REG_W-1:0]  in_rd;
  logic [IMM_W-1:0]  in_imm;
  logic [TGT_W-1:0]  in_target;

  logic              im_we;
  logic              im_ready;
  logic [ADDR_W-1:0] im_addr;
  logic [WORD_W-1:0] im_wdata;

  modport master (
    output in_valid, in_kind, in_rs, in_rt, in_rd, in_imm, in_target, im_ready,
    input  in_ready, im_we, im_addr, im_wdata
  );

  modport slave (
    input  in_valid, in_kind, in_rs, in_rt, in_rd, in_imm, in_target, im_ready,
    output in_ready, im_we, im_addr, im_wdata
  );

endinterface

// File: rtl/instr_encoder_pack.sv
// Combinational packer: request kind and fields -> 32-bit MIPS word plus legal flag.
module instr_pack
  import instr_encoder_pkg::*;
(
  input  req_t              req,
  output logic [WORD_W-1:0] word_c,
  output logic              legal_c
);

  // Unused fields are forced to zero by construction of each format.
  always_comb begin
    word_c  = '0;
    legal_c = 1'b1;
    case (req.kind)
      KIND_ADDU:  word_c = r_word(req.rs, req.rt, req.rd, FN_ADDU);
      KIND_SUBU:  word_c = r_word(req.rs, req.rt, req.rd, FN_SUBU);
      KIND_SLT:   word_c = r_word(req.rs, req.rt, req.rd, FN_SLT);
      KIND_JR:    word_c = r_word(req.rs, 5'd0, 5'd0, FN_JR);
      KIND_ORI:   word_c = i_word(OP_ORI,   req.rs, req.rt, req.imm);
      KIND_LW:    word_c = i_word(OP_LW,    req.rs, req.rt, req.imm);
      KIND_SW:    word_c = i_word(OP_SW,    req.rs, req.rt, req.imm);
      KIND_BEQ:   word_c = i_word(OP_BEQ,   req.rs, req.rt, req.imm);
      KIND_ADDI:  word_c = i_word(OP_ADDI,  req.rs, req.rt, req.imm);
      KIND_ADDIU: word_c = i_word(OP_ADDIU, req.rs, req.rt, req.imm);
      KIND_LUI:   word_c = i_word(OP_LUI,   5'd0,   req.rt, req.imm);
      KIND_J:     word_c = {OP_J,   req.target};
      KIND_JAL:   word_c = {OP_JAL, req.target};
      default:    legal_c = 1'b0;
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// Streaming MIPS instruction encoder/loader: packs requests and writes them
// sequentially into instruction memory through a registered, stallable port.
module instr_encoder
  import instr_encoder_pkg::*;
#(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DEPTH  = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  instr_encoder_if.slave    bus,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              err
);

  localparam int unsigned CNT_W = ADDR_W + 1;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                im_we_q, im_we_d;
  logic [ADDR_W-1:0]   im_addr_q, im_addr_d;
  logic [WORD_W-1:0]   im_wdata_q, im_wdata_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic                full_q, full_d;
  logic                err_q, err_d;

  logic                in_ready_c;
  logic                accept_c;
  logic                wr_done_c;
  logic [WORD_W-1:0]   pack_word_c;
  logic                pack_legal_c;
  req_t                req_c;

  assign req_c = '{kind: bus.in_kind, rs: bus.in_rs, rt: bus.in_rt, rd: bus.in_rd,
                   imm: bus.in_imm, target: bus.in_target};

  instr_pack u_pack (
    .req     (req_c),
    .word_c  (pack_word_c),
    .legal_c (pack_legal_c)
  );

  // A pending word counts toward DEPTH so a session never exceeds DEPTH writes.
  always_comb begin
    wr_done_c  = im_we_q && bus.im_ready;
    in_ready_c = reset && !start && (state_q == ST_RUN)
                 && (!im_we_q || bus.im_ready)
                 && ((count_q + CNT_W'(im_we_q)) < CNT_W'(DEPTH));
    accept_c   = bus.in_valid && in_ready_c;

    state_d    = state_q;
    addr_d     = addr_q;
    im_we_d    = im_we_q;
    im_addr_d  = im_addr_q;
    im_wdata_d = im_wdata_q;
    count_d    = count_q;
    full_d     = full_q;
    err_d      = err_q;

    if (start) begin
      state_d = ST_RUN;
      addr_d  = base_addr;
      im_we_d = 1'b0;
      count_d = '0;
      full_d  = 1'b0;
      err_d   = 1'b0;
    end else begin
      if (wr_done_c) begin
        im_we_d = 1'b0;
        count_d = count_q + CNT_W'(1);
        if ((count_q + CNT_W'(1)) == CNT_W'(DEPTH)) begin
          full_d  = 1'b1;
          state_d = ST_STOP;
        end
      end
      if (accept_c) begin
        if (pack_legal_c) begin
          im_we_d    = 1'b1;
          im_addr_d  = addr_q;
          im_wdata_d = pack_word_c;
          addr_d     = addr_q + ADDR_W'(1);
        end else begin
          err_d   = 1'b1;
          state_d = ST_STOP;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      im_we_q    <= 1'b0;
      im_addr_q  <= '0;
      im_wdata_q <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      im_we_q    <= im_we_d;
      im_addr_q  <= im_addr_d;
      im_wdata_q <= im_wdata_d;
      count_q    <= count_d;
      full_q     <= full_d;
      err_q      <= err_d;
    end
  end

  assign bus.in_ready = in_ready_c;
  assign bus.im_we    = im_we_q;
  assign bus.im_addr  = im_addr_q;
  assign bus.im_wdata = im_wdata_q;
  assign count        = count_q;
  assign full         = full_q;
  assign err          = err_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder: vector table, directed corner sequences, and a
// randomized run checked by a queue-based reference model of the load stream.
module tb_instr_encoder;

  localparam int unsigned AW_A = 10, DEPTH_A = 1024;
  localparam int unsigned AW_B = 2,  DEPTH_B = 4;

  logic clk = 1'b0;
  logic reset = 1'b0;

  logic            start_a = 1'b0;
  logic [AW_A-1:0] base_a = '0;
  logic [AW_A:0]   count_a;
  logic            full_a, err_a;

  logic            start_b = 1'b0;
  logic [AW_B-1:0] base_b = '0;
  logic [AW_B:0]   count_b;
  logic            full_b, err_b;

  instr_encoder_if #(.ADDR_W(AW_A)) ifa ();
  instr_encoder_if #(.ADDR_W(AW_B)) ifb ();

  instr_encoder #(.ADDR_W(AW_A), .DEPTH(DEPTH_A)) dut_a (
    .clk(clk), .reset(reset), .start(start_a), .base_addr(base_a), .bus(ifa.slave),
    .count(count_a), .full(full_a), .err(err_a));

  instr_encoder #(.ADDR_W(AW_B), .DEPTH(DEPTH_B)) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .base_addr(base_b), .bus(ifb.slave),
    .count(count_b), .full(full_b), .err(err_b));

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_a(input logic v, input logic [3:0] k, input logic [4:0] rs,
                         input logic [4:0] rt, input logic [4:0] rd,
                         input logic [15:0] imm, input logic [25:0] tgt);
    ifa.in_valid = v; ifa.in_kind = k; ifa.in_rs = rs; ifa.in_rt = rt;
    ifa.in_rd = rd; ifa.in_imm = imm; ifa.in_target = tgt;
  endtask

  // Called at posedge+1; returns at posedge+1 just after the start edge.
  task automatic start_session_a(input logic [AW_A-1:0] b);
    start_a = 1'b1;
    base_a  = b;
    @(negedge clk);
    tick();
    start_a = 1'b0;
  endtask

  // Reference encoder straight from the MIPS field layout (kind order 0..12).
  int unsigned op_of [13] = '{0, 0, 13, 35, 43, 4, 15, 8, 9, 0, 2, 3, 0};
  int unsigned fn_of [13] = '{33, 35, 0, 0, 0, 0, 0, 0, 0, 42, 0, 0, 8};

  function automatic logic [31:0] ref_encode(input logic [3:0] k, input logic [4:0] rs,
                                             input logic [4:0] rt, input logic [4:0] rd,
                                             input logic [15:0] imm, input logic [25:0] tgt,
                                             output bit legal);
    int unsigned r;
    int ki;
    ki = int'(k);
    legal = (ki < 13);
    if (!legal) return 32'd0;
    r = op_of[ki] << 26;
    if (ki == 10 || ki == 11) return r | 32'(tgt);
    if (ki == 0 || ki == 1 || ki == 9 || ki == 12) begin
      r = r | (32'(rs) << 21) | fn_of[ki];
      if (ki != 12) r = r | (32'(rt) << 16) | (32'(rd) << 11);
      return r;
    end
    if (ki != 6) r = r | (32'(rs) << 21);
    return r | (32'(rt) << 16) | 32'(imm);
  endfunction

  // Reference model for instance A: queue of accepted-but-unwritten words.
  typedef struct packed { logic [AW_A-1:0] addr; logic [31:0] word; } wr_t;
  wr_t             exp_q[$];
  logic [AW_A-1:0] m_next = '0;
  int              m_count = 0;
  bit              m_run = 0, m_err = 0, m_full = 0;
  bit              m_rdy, m_lg;
  logic [31:0]     m_w;

  always @(negedge clk) begin
    if (!reset) begin
      exp_q.delete();
      m_count = 0; m_run = 0; m_err = 0; m_full = 0;
    end else begin
      m_rdy = m_run && !start_a && (exp_q.size() == 0 || ifa.im_ready)
              && (exp_q.size() + m_count < int'(DEPTH_A));
      chk("mon_in_ready", 32'(ifa.in_ready), 32'(m_rdy));
      chk("mon_im_we", 32'(ifa.im_we), 32'(exp_q.size() != 0));
      if (exp_q.size() != 0) begin
        chk("mon_im_addr", 32'(ifa.im_addr), 32'(exp_q[0].addr));
        chk("mon_im_wdata", ifa.im_wdata, exp_q[0].word);
      end
      chk("mon_count", 32'(count_a), 32'(m_count));
      chk("mon_err", 32'(err_a), 32'(m_err));
      chk("mon_full", 32'(full_a), 32'(m_full));
      if (start_a) begin
        exp_q.delete();
        m_next = base_a; m_count = 0; m_run = 1; m_err = 0; m_full = 0;
      end else begin
        if (exp_q.size() != 0 && ifa.im_ready) begin
          void'(exp_q.pop_front());
          m_count++;
          if (m_count == int'(DEPTH_A)) begin m_full = 1; m_run = 0; end
        end
        if (ifa.in_valid && m_rdy) begin
          m_w = ref_encode(ifa.in_kind, ifa.in_rs, ifa.in_rt, ifa.in_rd,
                           ifa.in_imm, ifa.in_target, m_lg);
          if (m_lg) begin
            exp_q.push_back('{addr: m_next, word: m_w});
            m_next = m_next + 1'b1;
          end else begin
            m_err = 1; m_run = 0;
          end
        end
      end
    end
  end

  typedef struct {
    logic [3:0]  kind;
    logic [4:0]  rs, rt, rd;
    logic [15:0] imm;
    logic [25:0] tgt;
    logic [31:0] word;
  } vec_t;

  localparam int NV = 14;
  vec_t vec [NV];

  logic [AW_B-1:0] addrs_b[$];
  logic [AW_B-1:0] exp_b [4];
  int              acc_b;

  initial begin
    vec[0]  = '{4'd0,  5'd1,  5'd2,  5'd3,  16'h0000, 26'h0,       32'h00221821};
    vec[1]  = '{4'd2,  5'd0,  5'd4,  5'd0,  16'h1234, 26'h0,       32'h34041234};
    vec[2]  = '{4'd6,  5'd7,  5'd5,  5'd0,  16'hFFFF, 26'h0,       32'h3C05FFFF};
    vec[3]  = '{4'd11, 5'd0,  5'd0,  5'd0,  16'h0000, 26'h0000C00, 32'h0C000C00};
    vec[4]  = '{4'd12, 5'd31, 5'd9,  5'd9,  16'h0000, 26'h0,       32'h03E00008};
    vec[5]  = '{4'd5,  5'd1,  5'd2,  5'd0,  16'hFFFE, 26'h0,       32'h1022FFFE};
    vec[6]  = '{4'd1,  5'd4,  5'd5,  5'd6,  16'h0000, 26'h0,       32'h00853023};
    vec[7]  = '{4'd9,  5'd8,  5'd9,  5'd10, 16'h0000, 26'h0,       32'h0109502A};
    vec[8]  = '{4'd3,  5'd29, 5'd8,  5'd0,  16'h0004, 26'h0,       32'h8FA80004};
    vec[9]  = '{4'd4,  5'd29, 5'd31, 5'd0,  16'hFFFC, 26'h0,       32'hAFBFFFFC};
    vec[10] = '{4'd7,  5'd0,  5'd2,  5'd7,  16'h8000, 26'h0,       32'h20028000};
    vec[11] = '{4'd8,  5'd3,  5'd3,  5'd0,  16'h0001, 26'h0,       32'h24630001};
    vec[12] = '{4'd10, 5'd5,  5'd0,  5'd0,  16'h0000, 26'h3FFFFFF, 32'h0BFFFFFF};
    vec[13] = '{4'd0,  5'd31, 5'd31, 5'd31, 16'hFFFF, 26'h3FFFFFF, 32'h03FFF821};

    drive_a(0, 4'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0);
    ifa.im_ready = 1'b1;
    ifb.in_valid = 1'b0; ifb.in_kind = 4'd0; ifb.in_rs = 5'd1; ifb.in_rt = 5'd2;
    ifb.in_rd = 5'd3; ifb.in_imm = 16'h0; ifb.in_target = 26'h0; ifb.im_ready = 1'b1;

    // Reset values
    repeat (2) tick();
    @(negedge clk);
    chk("rst_im_we", 32'(ifa.im_we), 0);
    chk("rst_im_addr", 32'(ifa.im_addr), 0);
    chk("rst_im_wdata", ifa.im_wdata, 0);
    chk("rst_count", 32'(count_a), 0);
    chk("rst_full", 32'(full_a), 0);
    chk("rst_err", 32'(err_a), 0);
    chk("rst_b_im_we", 32'(ifb.im_we), 0);
    tick();
    reset = 1'b1;
    drive_a(1, 4'd0, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0);
    @(negedge clk);
    chk("idle_in_ready", 32'(ifa.in_ready), 0);
    tick();
    drive_a(0, 4'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0);
    @(negedge clk);
    chk("idle_no_write", 32'(ifa.im_we), 0);
    tick();

    // Vector table, one request at a time from base 0x010
    start_session_a(10'h010);
    for (int i = 0; i < NV; i++) begin
      drive_a(1, vec[i].kind, vec[i].rs, vec[i].rt, vec[i].rd, vec[i].imm, vec[i].tgt);
      @(negedge clk);
      chk("tbl_in_ready", 32'(ifa.in_ready), 1);
      tick();
      drive_a(0, 4'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0);
      @(negedge clk);
      chk("tbl_im_we", 32'(ifa.im_we), 1);
      chk("tbl_wdata", ifa.im_wdata, vec[i].word);
      chk("tbl_addr", 32'(ifa.im_addr), 32'h010 + 32'(i));
      chk("tbl_count", 32'(count_a), 32'(i));
      tick();
    end
    @(negedge clk);
    chk("tbl_final_count", 32'(count_a), NV);
    tick();

    // Back-to-back ori / lui at full throughput
    start_session_a(10'h010);
    drive_a(1, 4'd2, 5'd0, 5'd4, 5'd0, 16'h1234, 26'h0);
    @(negedge clk);
    chk("b2b_ready0", 32'(ifa.in_ready), 1);
    tick();
    drive_a(1, 4'd6, 5'd7, 5'd5, 5'd0, 16'hFFFF, 26'h0);
    @(negedge clk);
    chk("b2b_ready1", 32'(ifa.in_ready), 1);
    chk("b2b_ori_word", ifa.im_wdata, 32'h34041234);
    chk("b2b_ori_addr", 32'(ifa.im_addr), 32'h010);
    tick();
    drive_a(0, 4'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0);
    @(negedge clk);
    chk("b2b_lui_word", ifa.im_wdata, 32'h3C05FFFF);
    chk("b2b_lui_addr", 32'(ifa.im_addr), 32'h011);
    chk("b2b_ready2", 32'(ifa.in_ready), 1);
    tick();

    // jal then jr under a 3-cycle IM stall
    drive_a(1, 4'd11, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0000C00);
    @(negedge clk);
    chk("stall_ready_jal", 32'(ifa.in_ready), 1);
    tick();
    drive_a(1, 4'd12, 5'd31, 5'd9, 5'd9, 16'h0, 26'h0);
    ifa.im_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_in_ready", 32'(ifa.in_ready), 0);
      chk("stall_im_we", 32'(ifa.im_we), 1);
      chk("stall_addr", 32'(ifa.im_addr), 32'h012);
      chk("stall_wdata", ifa.im_wdata, 32'h0C000C00);
      tick();
    end
    ifa.im_ready = 1'b1;
    @(negedge clk);
    chk("stall_release_ready", 32'(ifa.in_ready), 1);
    tick();
    drive_a(0, 4'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0);
    @(negedge clk);
    chk("jr_wdata", ifa.im_wdata, 32'h03E00008);
    chk("jr_addr", 32'(ifa.im_addr), 32'h013);
    tick();

    // beq then an illegal kind: err, STOP, then restart clears it
    start_session_a(10'h020);
    drive_a(1, 4'd5, 5'd1, 5'd2, 5'd0, 16'hFFFE, 26'h0);
    @(negedge clk);
    chk("err_ready_beq", 32'(ifa.in_ready), 1);
    tick();
    drive_a(1, 4'd14, 5'd1, 5'd1, 5'd1, 16'h1111, 26'h0);
    @(negedge clk);
    chk("err_ready_ill", 32'(ifa.in_ready), 1);
    chk("err_beq_word", ifa.im_wdata, 32'h1022FFFE);
    tick();
    drive_a(1, 4'd0, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0);
    @(negedge clk);
    chk("err_flag", 32'(err_a), 1);
    chk("err_stop_ready", 32'(ifa.in_ready), 0);
    chk("err_count", 32'(count_a), 1);
    chk("err_no_write", 32'(ifa.im_we), 0);
    tick();
    drive_a(0, 4'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0);
    start_session_a(10'h020);
    drive_a(1, 4'd0, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0);
    @(negedge clk);
    chk("restart_err", 32'(err_a), 0);
    chk("restart_count", 32'(count_a), 0);
    chk("restart_ready", 32'(ifa.in_ready), 1);
    tick();
    drive_a(0, 4'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0);
    @(negedge clk);
    chk("restart_addr", 32'(ifa.im_addr), 32'h020);
    chk("restart_wdata", ifa.im_wdata, 32'h00221821);
    tick();

    // Reset during a stalled write, then start with a simultaneous request
    start_session_a(10'h050);
    drive_a(1, 4'd0, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0);
    ifa.im_ready = 1'b0;
    @(negedge clk);
    tick();
    drive_a(0, 4'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0);
    @(negedge clk);
    chk("mid_rst_pending", 32'(ifa.im_we), 1);
    tick();
    reset = 1'b0;
    @(negedge clk);
    tick();
    reset = 1'b1;
    ifa.im_ready = 1'b1;
    @(negedge clk);
    chk("mid_rst_im_we", 32'(ifa.im_we), 0);
    chk("mid_rst_addr", 32'(ifa.im_addr), 0);
    chk("mid_rst_wdata", ifa.im_wdata, 0);
    chk("mid_rst_count", 32'(count_a), 0);
    chk("mid_rst_ready", 32'(ifa.in_ready), 0);
    tick();
    start_a = 1'b1;
    base_a  = 10'h0AA;
    drive_a(1, 4'd0, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0);
    @(negedge clk);
    chk("start_prio_ready", 32'(ifa.in_ready), 0);
    tick();
    start_a = 1'b0;
    drive_a(1, 4'd2, 5'd0, 5'd1, 5'd0, 16'h00FF, 26'h0);
    @(negedge clk);
    chk("after_start_ready", 32'(ifa.in_ready), 1);
    tick();
    drive_a(0, 4'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0);
    @(negedge clk);
    chk("after_start_addr", 32'(ifa.im_addr), 32'h0AA);
    chk("after_start_wdata", ifa.im_wdata, 32'h340100FF);
    tick();

    // Small instance: base 3, five requests, wrap and DEPTH limit
    start_b = 1'b1;
    base_b  = 2'd3;
    @(negedge clk);
    tick();
    start_b = 1'b0;
    ifb.in_valid = 1'b1;
    acc_b = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (ifb.in_valid && ifb.in_ready) acc_b++;
      if (ifb.im_we && ifb.im_ready) begin
        chk("b_full_early", 32'(full_b), 0);
        addrs_b.push_back(ifb.im_addr);
      end
      tick();
    end
    ifb.in_valid = 1'b0;
    @(negedge clk);
    exp_b = '{2'd3, 2'd0, 2'd1, 2'd2};
    chk("b_accepts", 32'(acc_b), 4);
    chk("b_writes", 32'(addrs_b.size()), 4);
    for (int i = 0; i < 4 && i < addrs_b.size(); i++)
      chk("b_addr", 32'(addrs_b[i]), 32'(exp_b[i]));
    chk("b_full", 32'(full_b), 1);
    chk("b_count", 32'(count_b), 4);
    chk("b_err", 32'(err_b), 0);
    ifb.in_valid = 1'b1;
    @(negedge clk);
    chk("b_ready_after_full", 32'(ifb.in_ready), 0);
    tick();
    ifb.in_valid = 1'b0;

    // Randomized traffic against the reference model
    start_session_a(10'($urandom));
    for (int i = 0; i < 600; i++) begin
      start_a = ($urandom_range(0, 39) == 0);
      if (start_a) base_a = 10'($urandom);
      ifa.in_valid  = ($urandom_range(0, 2) != 0);
      ifa.in_kind   = ($urandom_range(0, 59) == 0) ? 4'(13 + $urandom_range(0, 2))
                                                    : 4'($urandom_range(0, 12));
      ifa.in_rs     = 5'($urandom);
      ifa.in_rt     = 5'($urandom);
      ifa.in_rd     = 5'($urandom);
      ifa.in_imm    = 16'($urandom);
      ifa.in_target = 26'($urandom);
      ifa.im_ready  = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      tick();
    end
    start_a = 1'b0;
    ifa.im_ready = 1'b1;
    drive_a(0, 4'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h0);
    repeat (4) tick();
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
